// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder: holds decoded code for HOLD_CYC cycles under start/busy/done; stall freezes the hold.
// Latency: code valid the cycle after start is accepted. Optional illegal-qualifier flag under ALU_CTRL_ILLEGAL_CHK_EN.
module alu_ctrl_seq #(
  parameter int unsigned          CTRL_W   = 4,
  parameter logic [CTRL_W-1:0]    MOV_CODE = CTRL_W'(0),
  parameter logic [CTRL_W-1:0]    ADD_CODE = CTRL_W'(1),
  parameter logic [CTRL_W-1:0]    SUB_CODE = CTRL_W'(2),
  parameter int unsigned          HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              internal_mov_n,
  input  logic              address_mode_n,
  input  logic              internal_inc_dec_n,
  input  logic              internal_dec_n,
  input  logic              stall,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              const_one,
  output logic [1:0]        op_class,
  output logic              busy,
`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  output logic              illegal,
`endif
  output logic              done
);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  localparam logic [3:0] RELOAD = 4'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              const_one_q, const_one_d;
  logic [1:0]        op_class_q, op_class_d;
  logic [CTRL_W-1:0] dec_code;
  logic              dec_one;
  logic [1:0]        dec_class;
  logic              accept;
  logic              done_c;

  // Priority decode; address mode only matters for normal-class operations.
  always_comb begin
    dec_code  = ctrl_in;
    dec_one   = 1'b0;
    dec_class = 2'd0;
    if (!internal_mov_n) begin
      if (internal_inc_dec_n) begin
        dec_code  = MOV_CODE;
        dec_class = 2'd1;
      end else if (internal_dec_n) begin
        dec_code  = ADD_CODE;
        dec_one   = 1'b1;
        dec_class = 2'd2;
      end else begin
        dec_code  = SUB_CODE;
        dec_one   = 1'b1;
        dec_class = 2'd3;
      end
    end else if (!address_mode_n) begin
      dec_code = ADD_CODE;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    const_one_d = const_one_q;
    op_class_d  = op_class_q;
    accept      = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      ACTIVE: begin
        if (!stall) begin
          if (cnt_q == 4'd0) begin
            done_c = 1'b1;
            if (start) accept = 1'b1;
            else       state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d     = ACTIVE;
      cnt_d       = RELOAD;
      ctrl_d      = dec_code;
      const_one_d = dec_one;
      op_class_d  = dec_class;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ctrl_q      <= '0;
      const_one_q <= 1'b0;
      op_class_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      const_one_q <= const_one_d;
      op_class_q  <= op_class_d;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  logic illegal_q, illegal_d;
  logic illegal_in;

  assign illegal_in = (internal_mov_n && (!internal_inc_dec_n || !internal_dec_n)) ||
                      (internal_inc_dec_n && !internal_dec_n);

  always_comb begin
    illegal_d = illegal_q;
    if (accept) illegal_d = illegal_in;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

  // An aborting reset suppresses the completion pulse.
  assign done      = done_c && !rst;
  assign busy      = (state_q == ACTIVE);
  assign ctrl_out  = ctrl_q;
  assign const_one = const_one_q;
  assign op_class  = op_class_q;

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the single-bit ALU control decoder in alu_ctrl.
- Decodes a CTRL_W-bit ALU control field together with the active-low internal-operation qualifiers (MOV, INC/DEC, DEC, address mode) into a final ALU control code and a forced-constant-one flag.
- Holds the decoded code stable for a programmable number of cycles under a start/busy/done handshake, so multi-cycle ALU/address operations see glitch-free control.
- Sits between the instruction decoder and the ALU operand/function muxes.

Parameters:
- CTRL_W, 4, width of ALU control field.
- MOV_CODE, 4'b0000, ALU code for pass-through (internal MOV).
- ADD_CODE, 4'b0001, ALU code for add (internal INC, address calc).
- SUB_CODE, 4'b0010, ALU code for subtract (internal DEC).
- HOLD_CYC, 1, cycles the code is held per operation; legal range 1..15.

Ports:
- clk, in, 1, system clock; rising edge.
- rst, in, 1, synchronous reset, active-high.
- start, in, 1, operation request; sampled on clk.
- ctrl_in, in, CTRL_W, normal-mode ALU control from instruction decoder.
- internal_mov_n, in, 1, active-low: internal operation.
- address_mode_n, in, 1, active-low: address-calculation mode.
- internal_inc_dec_n, in, 1, active-low: internal INC/DEC (qualified by internal_mov_n).
- internal_dec_n, in, 1, active-low: DEC rather than INC (qualified by internal_inc_dec_n).
- stall, in, 1, freezes the hold counter while busy.
- ctrl_out, out, CTRL_W, registered ALU control code.
- const_one, out, 1, registered: ALU B operand forced to 1.
- op_class, out, 2, registered: 0 normal, 1 MOV, 2 INC, 3 DEC.
- busy, out, 1, operation in progress.
- done, out, 1, single-cycle completion pulse.

Behaviour:
- Decode is combinational from inputs sampled on the accepting edge. Priority, all qualifiers active-low:
  - internal_mov_n=1: normal. code = ADD_CODE if address_mode_n=0, else ctrl_in; const_one=0; class 0.
  - internal_mov_n=0, internal_inc_dec_n=1: code = MOV_CODE; const_one=0; class 1.
  - internal_mov_n=0, internal_inc_dec_n=0, internal_dec_n=1: code = ADD_CODE; const_one=1; class 2.
  - internal_mov_n=0, internal_inc_dec_n=0, internal_dec_n=0: code = SUB_CODE; const_one=1; class 3.
  - address_mode_n has no effect on the internal classes.
- States: IDLE, ACTIVE; 4-bit counter cnt.
- IDLE:
  - busy=0, done=0.
  - start=1 → latch decode into ctrl_out/const_one/op_class, cnt=HOLD_CYC-1, go to ACTIVE.
- ACTIVE:
  - busy=1.
  - stall=1: cnt and outputs frozen; done=0.
  - stall=0 and cnt!=0: cnt decrements.
  - stall=0 and cnt==0: done=1 this cycle (combinational from state).
    - start=1 in this cycle: accepted back-to-back. New decode is latched, cnt reloads, and the FSM stays in ACTIVE with no idle bubble.
    - Otherwise: go to IDLE.
  - start while ACTIVE and not finishing is ignored; no queueing.
- Latency and duration:
  - start accepted at edge T: ctrl_out valid from cycle T+1.
  - With stall=0, busy=1 for exactly HOLD_CYC cycles; done is high in the last of them.
- ctrl_out, const_one and op_class hold their last values in IDLE until the next accepted start.
- Reset:
  - rst=1 forces IDLE, cnt=0, ctrl_out=0, const_one=0, op_class=0, busy=0, done=0.
  - Reset mid-operation aborts with no done pulse.
  - rst has priority over start.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_CHK_EN.
- Defined:
  - Adds output illegal (1 bit, registered, reset 0). It is set on the accepting edge when internal_mov_n=1 and (internal_inc_dec_n=0 or internal_dec_n=0), or when internal_inc_dec_n=1 and internal_dec_n=0.
  - The operation still proceeds using the priority decode above.
  - illegal clears on the next accepted start with legal inputs.
- Undefined: port absent; such combinations are silently decoded by priority.

Test Plan:
- Reset, then start=1 with internal_mov_n=1, address_mode_n=1, ctrl_in=4'b1010, HOLD_CYC=1 → next cycle ctrl_out=1010, op_class=0, const_one=0, busy=1, done=1; then IDLE with ctrl_out still 1010.
- Normal with address_mode_n=0, ctrl_in=4'b0111 → ctrl_out=ADD_CODE (0001), const_one=0.
- internal_mov_n=0, internal_inc_dec_n=0, internal_dec_n=0, HOLD_CYC=3, stall=1 in the 2nd busy cycle → ctrl_out=0010, const_one=1, op_class=3; busy for 4 cycles, done only in the 4th.
- Back-to-back: INC op with start held high through done → second op (MOV, class 1) latched in the done cycle; busy never drops; done pulses once per op.
- rst=1 in the 2nd cycle of a HOLD_CYC=4 op → next cycle all outputs 0, IDLE, no done.
- ALU_CTRL_ILLEGAL_CHK_EN: internal_mov_n=1, internal_inc_dec_n=0 → illegal=1, ctrl_out=ctrl_in; next legal start → illegal=0.
